// File: rtl/alt_vipvfr131_prc_slave_reader_if.sv
// Bus bundle for the packet-reader core.
//   slave_*       : register port driven by the frame-reader controller
//   read_master_* : Avalon-MM burst read master towards memory
//   fifo_free_words, out_* : push-only packet stream into the downstream FIFO
// Modport "slave" is the core's view; modport "master" is the surrounding
// system's view (controller, memory and FIFO together).
interface alt_vipvfr131_prc_slave_reader_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BURST_WIDTH = 5,
  parameter int FREE_WIDTH  = 16
);
  logic [2:0]             slave_address;
  logic                   slave_write;
  logic [31:0]            slave_writedata;
  logic                   slave_read;
  logic [31:0]            slave_readdata;
  logic                   slave_interrupt;

  logic [ADDR_WIDTH-1:0]  read_master_address;
  logic                   read_master_read;
  logic [BURST_WIDTH-1:0] read_master_burstcount;
  logic                   read_master_waitrequest;
  logic [DATA_WIDTH-1:0]  read_master_readdata;
  logic                   read_master_readdatavalid;

  logic [FREE_WIDTH-1:0]  fifo_free_words;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_sop;
  logic                   out_eop;
  logic [3:0]             out_packet_type;
  logic [31:0]            out_samples;

  modport slave (
    input  slave_address, slave_write, slave_writedata, slave_read,
    output slave_readdata, slave_interrupt,
    output read_master_address, read_master_read, read_master_burstcount,
    input  read_master_waitrequest, read_master_readdata, read_master_readdatavalid,
    input  fifo_free_words,
    output out_data, out_valid, out_sop, out_eop, out_packet_type, out_samples
  );

  modport master (
    output slave_address, slave_write, slave_writedata, slave_read,
    input  slave_readdata, slave_interrupt,
    input  read_master_address, read_master_read, read_master_burstcount,
    output read_master_waitrequest, read_master_readdata, read_master_readdatavalid,
    output fifo_free_words,
    input  out_data, out_valid, out_sop, out_eop, out_packet_type, out_samples
  );
endinterface

// File: rtl/alt_vipvfr131_prc_slave_reader.sv
// Packet-reader core. Holds the programming registers (word addresses 0-6),
// fetches WORDS memory words in bursts of up to MAX_BURST on a go command,
// streams them out with sop/eop and raises a maskable W1C end-of-packet irq.
// Ports:
//   clock   : core clock
//   reset_n : asynchronous active-low reset
//   bus     : register slave, burst read master and output stream (see _if)
module alt_vipvfr131_prc_slave_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_BURST   = 16,
  parameter int BURST_WIDTH = 5,
  parameter int FREE_WIDTH  = 16
) (
  input logic clock,
  input logic reset_n,
  alt_vipvfr131_prc_slave_reader_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;

  logic                   r_irq_en, r_busy, r_eop_pending;
  logic [31:0]            r_sh_addr, r_sh_samples, r_sh_words;
  logic [3:0]             r_sh_type;
  logic [31:0]            r_readdata, w_rdata;

  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [31:0]            r_words, r_remaining, r_requested, r_received;
  logic                   r_read;
  logic [BURST_WIDTH-1:0] r_burst, w_burst;

  logic [DATA_WIDTH-1:0]  r_out_data;
  logic                   r_out_valid, r_out_sop, r_out_eop;
  logic [3:0]             r_out_type;
  logic [31:0]            r_out_samples;

  logic w_go, w_accept, w_rx, w_space;

  assign w_go     = bus.slave_write && (bus.slave_address == 3'd0) &&
                    bus.slave_writedata[0] && (r_state == S_IDLE);
  assign w_accept = r_read && !bus.read_master_waitrequest;
  assign w_rx     = bus.read_master_readdatavalid &&
                    ((r_state == S_ISSUE) || (r_state == S_DRAIN));

  always_comb begin
    w_burst = BURST_WIDTH'(r_remaining);
    if (r_remaining > 32'(MAX_BURST)) w_burst = BURST_WIDTH'(MAX_BURST);
  end

  // Request only when the FIFO can absorb everything in flight plus this burst.
  assign w_space = (33'(r_requested - r_received) + 33'(w_burst)) <= 33'(bus.fifo_free_words);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = (r_sh_words == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_accept && (r_remaining == 32'(r_burst))) w_next = S_DRAIN;
      S_DRAIN: if (r_received == r_words) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (bus.slave_address)
      3'd0:    w_rdata = {30'b0, r_irq_en, r_busy};
      3'd1:    w_rdata = {31'b0, r_busy};
      3'd2:    w_rdata = {30'b0, r_eop_pending, 1'b0};
      3'd3:    w_rdata = r_sh_addr;
      3'd4:    w_rdata = {28'b0, r_sh_type};
      3'd5:    w_rdata = r_sh_samples;
      3'd6:    w_rdata = r_sh_words;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en      <= 1'b0;
      r_busy        <= 1'b0;
      r_eop_pending <= 1'b0;
      r_sh_addr     <= '0;
      r_sh_type     <= '0;
      r_sh_samples  <= '0;
      r_sh_words    <= '0;
      r_readdata    <= '0;
    end else begin
      if (bus.slave_write) begin
        case (bus.slave_address)
          3'd0:    r_irq_en     <= bus.slave_writedata[1];
          3'd3:    r_sh_addr    <= bus.slave_writedata;
          3'd4:    r_sh_type    <= bus.slave_writedata[3:0];
          3'd5:    r_sh_samples <= bus.slave_writedata;
          3'd6:    r_sh_words   <= bus.slave_writedata;
          default: ;
        endcase
      end
      // Setting from DONE takes priority over a simultaneous W1C.
      if (r_state == S_DONE)
        r_eop_pending <= 1'b1;
      else if (bus.slave_write && (bus.slave_address == 3'd2) && bus.slave_writedata[1])
        r_eop_pending <= 1'b0;
      if (w_go && (r_sh_words != '0)) r_busy <= 1'b1;
      else if (r_state == S_DONE)     r_busy <= 1'b0;
      if (bus.slave_read) r_readdata <= w_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr        <= '0;
      r_words       <= '0;
      r_remaining   <= '0;
      r_requested   <= '0;
      r_received    <= '0;
      r_read        <= 1'b0;
      r_burst       <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_sop     <= 1'b0;
      r_out_eop     <= 1'b0;
      r_out_type    <= '0;
      r_out_samples <= '0;
    end else begin
      if (w_go) begin
        r_addr        <= ADDR_WIDTH'(r_sh_addr);
        r_words       <= r_sh_words;
        r_remaining   <= r_sh_words;
        r_requested   <= '0;
        r_received    <= '0;
        r_out_type    <= r_sh_type;
        r_out_samples <= r_sh_samples;
      end
      // read/address/burstcount are registered so they stay frozen while stalled.
      if (r_state == S_ISSUE) begin
        if (w_accept) begin
          r_read      <= 1'b0;
          r_addr      <= r_addr + ADDR_WIDTH'(r_burst) * ADDR_WIDTH'(BYTES);
          r_remaining <= r_remaining - 32'(r_burst);
          r_requested <= r_requested + 32'(r_burst);
        end else if (!r_read && (r_remaining != '0) && w_space) begin
          r_read  <= 1'b1;
          r_burst <= w_burst;
        end
      end
      if (w_rx) begin
        r_received <= r_received + 32'd1;
        r_out_data <= bus.read_master_readdata;
      end
      r_out_valid <= w_rx;
      r_out_sop   <= w_rx && (r_received == '0);
      r_out_eop   <= w_rx && (r_received == r_words - 32'd1);
    end
  end

  assign bus.slave_readdata         = r_readdata;
  assign bus.slave_interrupt        = r_eop_pending & r_irq_en;
  assign bus.read_master_address    = r_addr;
  assign bus.read_master_read       = r_read;
  assign bus.read_master_burstcount = r_burst;
  assign bus.out_data               = r_out_data;
  assign bus.out_valid              = r_out_valid;
  assign bus.out_sop                = r_out_sop;
  assign bus.out_eop                = r_out_eop;
  assign bus.out_packet_type        = r_out_type;
  assign bus.out_samples            = r_out_samples;
endmodule
